// File: rtl/instr_encoder.sv
// instr_encoder: turns a field-level instruction request into MIPS32 words.
// Most ops become exactly one word; LI may expand into a LUI/ORI pair.
// Requests are captured in one cycle and the first word is presented from
// the next clock edge, held stable until the consumer takes it.
module instr_encoder #(
    parameter int LI_SHORT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err_illegal
);

    // Request operation codes
    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUBU  = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_ADDIU = 5'd12;
    localparam logic [4:0] OP_ANDI  = 5'd13;
    localparam logic [4:0] OP_ORI   = 5'd14;
    localparam logic [4:0] OP_XORI  = 5'd15;
    localparam logic [4:0] OP_LUI   = 5'd16;
    localparam logic [4:0] OP_LW    = 5'd17;
    localparam logic [4:0] OP_SW    = 5'd18;
    localparam logic [4:0] OP_BEQ   = 5'd19;
    localparam logic [4:0] OP_BNE   = 5'd20;
    localparam logic [4:0] OP_J     = 5'd21;
    localparam logic [4:0] OP_JAL   = 5'd22;
    localparam logic [4:0] OP_JR    = 5'd23;
    localparam logic [4:0] OP_MFC0  = 5'd24;
    localparam logic [4:0] OP_MTC0  = 5'd25;
    localparam logic [4:0] OP_ERET  = 5'd26;
    localparam logic [4:0] OP_LI    = 5'd27;
    localparam logic [4:0] OP_MOVE  = 5'd28;

    // MIPS primary opcodes and SPECIAL function codes
    localparam logic [5:0] MIPS_SPECIAL = 6'h00;
    localparam logic [5:0] MIPS_J       = 6'h02;
    localparam logic [5:0] MIPS_JAL     = 6'h03;
    localparam logic [5:0] MIPS_BEQ     = 6'h04;
    localparam logic [5:0] MIPS_BNE     = 6'h05;
    localparam logic [5:0] MIPS_ADDIU   = 6'h09;
    localparam logic [5:0] MIPS_ANDI    = 6'h0C;
    localparam logic [5:0] MIPS_ORI     = 6'h0D;
    localparam logic [5:0] MIPS_XORI    = 6'h0E;
    localparam logic [5:0] MIPS_LUI     = 6'h0F;
    localparam logic [5:0] MIPS_COP0    = 6'h10;
    localparam logic [5:0] MIPS_LW      = 6'h23;
    localparam logic [5:0] MIPS_SW      = 6'h2B;
    localparam logic [5:0] FN_SLL       = 6'h00;
    localparam logic [5:0] FN_SRL       = 6'h02;
    localparam logic [5:0] FN_SRA       = 6'h03;
    localparam logic [5:0] FN_JR        = 6'h08;
    localparam logic [5:0] FN_ADDU      = 6'h21;
    localparam logic [5:0] FN_SUBU      = 6'h23;
    localparam logic [5:0] FN_AND       = 6'h24;
    localparam logic [5:0] FN_OR        = 6'h25;
    localparam logic [5:0] FN_XOR       = 6'h26;
    localparam logic [5:0] FN_NOR       = 6'h27;
    localparam logic [5:0] FN_SLT       = 6'h2A;
    localparam logic [5:0] FN_SLTU      = 6'h2B;
    localparam logic [4:0] COP0_MF      = 5'h00;
    localparam logic [4:0] COP0_MT      = 5'h04;
    localparam logic [31:0] ERET_WORD   = 32'h4200_0018;

    // IDLE: nothing held; ONE: holding a last word; FIRST: LUI held, ORI pending
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        FIRST = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pending_q, pending_d;
    logic        err_q, err_d;

    logic [31:0] enc_first;
    logic [31:0] enc_second;
    logic        enc_two;
    logic        enc_illegal;
    logic        accept;
    logic        li_is_short;

    assign li_is_short = (LI_SHORT != 0) && (req_imm[31:16] == 16'h0000);

    // Encode the request fields into up to two instruction words
    always_comb begin
        enc_first   = 32'h0000_0000;
        enc_second  = 32'h0000_0000;
        enc_two     = 1'b0;
        enc_illegal = 1'b0;
        case (req_op)
            OP_NOP:   enc_first = 32'h0000_0000;
            OP_ADDU:  enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_ADDU};
            OP_SUBU:  enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_SUBU};
            OP_AND:   enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_AND};
            OP_OR:    enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_OR};
            OP_XOR:   enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_XOR};
            OP_NOR:   enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_NOR};
            OP_SLT:   enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_SLT};
            OP_SLTU:  enc_first = {MIPS_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_SLTU};
            OP_SLL:   enc_first = {MIPS_SPECIAL, 5'd0, req_rt, req_rd, req_shamt, FN_SLL};
            OP_SRL:   enc_first = {MIPS_SPECIAL, 5'd0, req_rt, req_rd, req_shamt, FN_SRL};
            OP_SRA:   enc_first = {MIPS_SPECIAL, 5'd0, req_rt, req_rd, req_shamt, FN_SRA};
            OP_ADDIU: enc_first = {MIPS_ADDIU, req_rs, req_rt, req_imm[15:0]};
            OP_ANDI:  enc_first = {MIPS_ANDI, req_rs, req_rt, req_imm[15:0]};
            OP_ORI:   enc_first = {MIPS_ORI, req_rs, req_rt, req_imm[15:0]};
            OP_XORI:  enc_first = {MIPS_XORI, req_rs, req_rt, req_imm[15:0]};
            OP_LUI:   enc_first = {MIPS_LUI, 5'd0, req_rt, req_imm[15:0]};
            OP_LW:    enc_first = {MIPS_LW, req_rs, req_rt, req_imm[15:0]};
            OP_SW:    enc_first = {MIPS_SW, req_rs, req_rt, req_imm[15:0]};
            OP_BEQ:   enc_first = {MIPS_BEQ, req_rs, req_rt, req_imm[15:0]};
            OP_BNE:   enc_first = {MIPS_BNE, req_rs, req_rt, req_imm[15:0]};
            OP_J:     enc_first = {MIPS_J, req_imm[25:0]};
            OP_JAL:   enc_first = {MIPS_JAL, req_imm[25:0]};
            OP_JR:    enc_first = {MIPS_SPECIAL, req_rs, 15'd0, FN_JR};
            OP_MFC0:  enc_first = {MIPS_COP0, COP0_MF, req_rt, req_rd, 8'd0, req_imm[2:0]};
            OP_MTC0:  enc_first = {MIPS_COP0, COP0_MT, req_rt, req_rd, 8'd0, req_imm[2:0]};
            OP_ERET:  enc_first = ERET_WORD;
            OP_LI: begin
                if (li_is_short) begin
                    enc_first = {MIPS_ORI, 5'd0, req_rt, req_imm[15:0]};
                end else begin
                    enc_first  = {MIPS_LUI, 5'd0, req_rt, req_imm[31:16]};
                    enc_second = {MIPS_ORI, req_rt, req_rt, req_imm[15:0]};
                    enc_two    = 1'b1;
                end
            end
            OP_MOVE:  enc_first = {MIPS_SPECIAL, req_rs, 5'd0, req_rd, 5'd0, FN_ADDU};
            default:  enc_illegal = 1'b1;
        endcase
    end

    assign req_ready = (state_q == IDLE) || ((state_q == ONE) && out_ready);
    assign accept    = req_valid && req_ready;

    // Next-state logic: accept new requests, advance LI pairs, drain to IDLE
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pending_d = pending_q;
        err_d     = accept && enc_illegal;
        case (state_q)
            IDLE, ONE: begin
                if (accept) begin
                    if (enc_illegal) begin
                        state_d = IDLE;
                        instr_d = 32'h0000_0000;
                    end else if (enc_two) begin
                        state_d   = FIRST;
                        instr_d   = enc_first;
                        pending_d = enc_second;
                    end else begin
                        state_d = ONE;
                        instr_d = enc_first;
                    end
                end else if ((state_q == ONE) && out_ready) begin
                    state_d = IDLE;
                    instr_d = 32'h0000_0000;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    state_d = ONE;
                    instr_d = pending_q;
                end
            end
            default: begin
                state_d = IDLE;
                instr_d = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers; reset drops any pending second word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            instr_q   <= 32'h0000_0000;
            pending_q <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign out_valid   = (state_q == ONE) || (state_q == FIRST);
    assign out_last    = (state_q == ONE);
    assign out_instr   = instr_q;
    assign err_illegal = err_q;

endmodule
